pattern_event_logger: RTL

//  Downstream consumer of the pattern-detect multiplier stage (C product + pattern_detection flag).

---
 rtl/pattern_log_pkg.sv | 26 ++
 rtl/pattern_log_fifo.sv | 98 +++++++++
 rtl/pattern_event_logger.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pattern_log_pkg.sv
// Shared defaults, the FIFO entry layout and a saturating-increment helper
// for the pattern-detect event logger.
package pattern_log_pkg;

    localparam int unsigned DEF_DATA_W = 21;
    localparam int unsigned DEF_TS_W   = 16;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef struct packed {
        logic [DEF_TS_W-1:0]   ts;
        logic [DEF_DATA_W-1:0] data;
    } log_entry_t;

    // Increments val by one unless it already holds the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32'd32 - width);
        if (val == max_v) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pattern_log_fifo.sv
// Synchronous show-ahead FIFO. The head is held in a register so that it keeps
// its last value once the FIFO runs empty.
module pattern_log_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q, valid_d;
    logic          full_s, empty_s, do_push_s, do_pop_s;

    assign full_s  = (level_q == LW'(DEPTH));
    assign empty_s = (level_q == {LW{1'b0}});

    // Next pointers, level and head; the head is taken from the write data when
    // the entry being pushed becomes the new head in the same cycle.
    always_comb begin
        do_pop_s  = pop_i & ~empty_s;
        do_push_s = push_i & (~full_s | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        head_d    = head_q;
        if (clr_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push_s);
            rd_ptr_d = rd_ptr_q + AW'(do_pop_s);
            level_d  = level_q + LW'(do_push_s) - LW'(do_pop_s);
            if (level_d == {LW{1'b0}}) begin
                head_d = head_q;
            end else if ((level_q == {LW{1'b0}}) || ((level_q == LW'(1'b1)) && do_pop_s)) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        valid_d = (level_d != {LW{1'b0}});
    end

    // Control state and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            head_q   <= {W{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (do_push_s && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign rdata_o = head_q;
    assign valid_o = valid_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign level_o = level_q;

endmodule

// File: rtl/pattern_event_logger.sv
// Timestamps rising edges of the pattern-detect flag, queues {ts, C} for a
// valid/ready consumer and keeps saturating debug statistics.
module pattern_event_logger
    import pattern_log_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TS_W   = DEF_TS_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        C,
    input  logic                     pattern_detection,
    input  logic                     clear,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [DATA_W-1:0]        evt_data,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         event_cnt,
    output logic [CNT_W-1:0]         max_run,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned EW = TS_W + DATA_W;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic             pd_q;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             event_s, push_s, pop_s, drop_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [EW-1:0]    head_s;

    assign event_s = pattern_detection & ~pd_q;
    assign pop_s   = evt_ready & ~fifo_empty_s & ~clear;
    assign push_s  = event_s & ~clear;
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    assign drop_s  = push_s & fifo_full_s & ~pop_s;

    // Timestamp and statistics next state; clear wins over events but not over the timestamp.
    always_comb begin
        ts_d      = ts_q + TS_W'(1'b1);
        run_d     = run_q;
        max_d     = max_q;
        evt_cnt_d = evt_cnt_q;
        drop_d    = drop_q;
        if (clear) begin
            run_d     = {CNT_W{1'b0}};
            max_d     = {CNT_W{1'b0}};
            evt_cnt_d = {CNT_W{1'b0}};
            drop_d    = {CNT_W{1'b0}};
        end else begin
            if (pattern_detection) begin
                run_d = CNT_W'(sat_inc(32'(run_q), CNT_W));
            end else begin
                run_d = {CNT_W{1'b0}};
            end
            if (run_d > max_q) begin
                max_d = run_d;
            end else begin
                max_d = max_q;
            end
            if (event_s) begin
                evt_cnt_d = CNT_W'(sat_inc(32'(evt_cnt_q), CNT_W));
            end else begin
                evt_cnt_d = evt_cnt_q;
            end
            if (drop_s) begin
                drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Timestamp, edge-detect and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q      <= {TS_W{1'b0}};
            pd_q      <= 1'b0;
            run_q     <= {CNT_W{1'b0}};
            max_q     <= {CNT_W{1'b0}};
            evt_cnt_q <= {CNT_W{1'b0}};
            drop_q    <= {CNT_W{1'b0}};
        end else begin
            ts_q      <= ts_d;
            pd_q      <= pattern_detection;
            run_q     <= run_d;
            max_q     <= max_d;
            evt_cnt_q <= evt_cnt_d;
            drop_q    <= drop_d;
        end
    end

    pattern_log_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({ts_q, C}),
        .rdata_o (head_s),
        .valid_o (evt_valid),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level)
    );

    assign evt_ts    = head_s[EW-1:DATA_W];
    assign evt_data  = head_s[DATA_W-1:0];
    assign event_cnt = evt_cnt_q;
    assign max_run   = max_q;
    assign drop_cnt  = drop_q;

endmodule
